vedic_mac_accum: RTL and testbench

Sequential multiply-accumulate stage built around the existing combinational vedic_8X8 multiplier (ports a, b, c). It accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers each 16-bit product. It sums N_TERMS consecutive products into one frame result. Each frame result is presented downstream over a second valid/ready handshake with a sticky overflow flag. The block sits directly downstream of the operand source and consumes the multiplier's product.

---
 rtl/vedic_pkg.sv | 23 ++
 rtl/vedic_mac_accum_if.sv | 31 +++
 rtl/vedic_8X8.sv | 41 ++++
 rtl/vedic_mac_accum.sv | 107 ++++++++++
 tb/tb_vedic_mac_accum.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// vedic_pkg : shared types and constants for the vedic multiply-accumulate
// Rev 1.0
// ============================================================================
package vedic_pkg;

  localparam int VEDIC_IN_W   = 8;
  localparam int VEDIC_PROD_W = 16;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Never returns 0 so a 1-bit counter still exists for the smallest frame.
  function automatic int cnt_width(input int n_terms);
    return (n_terms <= 2) ? 1 : $clog2(n_terms);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vedic_mac_accum_if.sv
`default_nettype none
// ============================================================================
// vedic_mac_accum_if : operand-in and result-out valid/ready bundle
// Rev 1.0
// ============================================================================
interface vedic_mac_accum_if #(
  parameter int ACC_W = 24
);
  import vedic_pkg::*;

  logic [VEDIC_IN_W-1:0] a;
  logic [VEDIC_IN_W-1:0] b;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_W-1:0]      sum;
  logic                  sum_valid;
  logic                  sum_ready;
  logic                  ovf;

  modport master (
    output a, b, in_valid, sum_ready,
    input  in_ready, sum, sum_valid, ovf
  );

  modport slave (
    input  a, b, in_valid, sum_ready,
    output in_ready, sum, sum_valid, ovf
  );

endinterface
`default_nettype wire

// File: rtl/vedic_8X8.sv
`default_nettype none
// ============================================================================
// vedic_8X8 : combinational 8x8 unsigned Urdhva-Tiryagbhyam multiplier
// Rev 1.0
// ============================================================================
module vedic_8X8 (
  input  wire logic [7:0]  a,
  input  wire logic [7:0]  b,
  output logic      [15:0] c
);

  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic p0, p1, p2, cx;
    p0 = x[0] & y[0];
    p1 = (x[1] & y[0]) ^ (x[0] & y[1]);
    cx = (x[1] & y[0]) & (x[0] & y[1]);
    p2 = (x[1] & y[1]) ^ cx;
    return {(x[1] & y[1]) & cx, p2, p1, p0};
  endfunction

  // Four vertical/crosswise partials, recombined at their binary weights.
  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vm2(x[1:0], y[1:0]);
    q1 = vm2(x[3:2], y[1:0]);
    q2 = vm2(x[1:0], y[3:2]);
    q3 = vm2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0] w_q0, w_q1, w_q2, w_q3;

  assign w_q0 = vm4(a[3:0], b[3:0]);
  assign w_q1 = vm4(a[7:4], b[3:0]);
  assign w_q2 = vm4(a[3:0], b[7:4]);
  assign w_q3 = vm4(a[7:4], b[7:4]);

  assign c = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};

endmodule
`default_nettype wire

// File: rtl/vedic_mac_accum.sv
`default_nettype none
// ============================================================================
// vedic_mac_accum : sums N_TERMS vedic products per frame, result handshaked
// Rev 1.0
// ============================================================================
module vedic_mac_accum
  import vedic_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  wire logic       clk,
  input  wire logic       rst,
  vedic_mac_accum_if.slave bus
);

  localparam int                c_cnt_w    = cnt_width(N_TERMS);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(N_TERMS - 1);

  state_t                  r_state;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [VEDIC_PROD_W-1:0] r_p;
  logic                    r_p_vld;
  logic                    r_p_last;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_ovf_int;
  logic [ACC_W-1:0]        r_sum;
  logic                    r_ovf;
  logic                    r_sum_valid;

  logic [VEDIC_PROD_W-1:0] w_prod;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_last_term;
  logic [ACC_W:0]          w_total;

  vedic_8X8 u_mult (
    .a (bus.a),
    .b (bus.b),
    .c (w_prod)
  );

  // in_ready is forced low while reset is asserted, not just after the edge.
  assign w_in_ready  = (r_state == ACC) && !rst;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last_term = (r_cnt == c_last_cnt);
  assign w_total     = {1'b0, r_acc} + {{(ACC_W + 1 - VEDIC_PROD_W){1'b0}}, r_p};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_cnt       <= '0;
      r_p         <= '0;
      r_p_vld     <= 1'b0;
      r_p_last    <= 1'b0;
      r_acc       <= '0;
      r_ovf_int   <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      r_p_vld <= w_accept;
      if (w_accept) begin
        r_p      <= w_prod;
        r_p_last <= w_last_term;
        r_cnt    <= w_last_term ? '0 : r_cnt + 1'b1;
      end

      // The carry out of w_total is the per-term overflow; it is made sticky.
      if (r_p_vld) begin
        if (r_p_last) begin
          r_sum       <= w_total[ACC_W-1:0];
          r_ovf       <= r_ovf_int | w_total[ACC_W];
          r_sum_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf_int   <= 1'b0;
        end else begin
          r_acc     <= w_total[ACC_W-1:0];
          r_ovf_int <= r_ovf_int | w_total[ACC_W];
        end
      end

      case (r_state)
        ACC: begin
          if (w_accept && w_last_term) r_state <= WAIT;
        end
        WAIT: begin
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_sum_valid && bus.sum_ready) begin
            r_sum_valid <= 1'b0;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sum       = r_sum;
  assign bus.ovf       = r_ovf;
  assign bus.sum_valid = r_sum_valid;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mac_accum.sv
`default_nettype none
// ============================================================================
// tb_vedic_mac_accum : table-driven frames with a result scoreboard, run on
// a default (ACC_W=24) and a narrow (ACC_W=17) instance in lockstep. Rev 1.0
// ============================================================================
module tb_vedic_mac_accum;

  typedef struct {
    int a [4];
    int b [4];
    logic [3:0] gap;
    int exp24;
    int ovf24;
    string name;
  } vec_t;

  typedef struct {
    int s24;
    int o24;
    int s17;
    int o17;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;
  exp_t sb[$];

  vedic_mac_accum_if #(.ACC_W(24)) bus24 ();
  vedic_mac_accum_if #(.ACC_W(17)) bus17 ();

  vedic_mac_accum #(.N_TERMS(4), .ACC_W(24)) dut24 (.clk(clk), .rst(rst), .bus(bus24));
  vedic_mac_accum #(.N_TERMS(4), .ACC_W(17)) dut17 (.clk(clk), .rst(rst), .bus(bus17));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic set_in(input int a, input int b, input logic v);
    bus24.a = 8'(a);  bus24.b = 8'(b);  bus24.in_valid = v;
    bus17.a = 8'(a);  bus17.b = 8'(b);  bus17.in_valid = v;
  endtask

  task automatic set_sr(input logic r);
    bus24.sum_ready = r;
    bus17.sum_ready = r;
  endtask

  // Expected values for the narrow instance come from a plain integer model.
  task automatic push_frame(input int a [4], input int b [4], input int e24, input int o24);
    exp_t e;
    int total;
    total = 0;
    for (int i = 0; i < 4; i++) total += a[i] * b[i];
    e.s24 = e24;
    e.o24 = o24;
    e.s17 = total % (1 << 17);
    e.o17 = (total >= (1 << 17)) ? 1 : 0;
    sb.push_back(e);
  endtask

  // Entered and left at posedge+1; returns once the pair has been accepted.
  task automatic send_pair(input int a, input int b, input logic gap);
    logic got;
    if (gap) begin
      set_in(0, 0, 1'b0);
      @(posedge clk); #1;
    end
    set_in(a, b, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus24.in_ready;
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus24.sum_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Result monitor: latency, values, back-pressure stability, re-arm of in_ready.
  logic prev_sv, prev_hs;
  int   last_acc_cyc;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_sv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("in_ready_after_hs", bus24.in_ready, 1);
        check("sum_valid_drop", bus24.sum_valid, 0);
      end
      if (bus24.sum_valid && !prev_sv) begin
        check("latency", cyc - last_acc_cyc, 2);
        check("sum_valid17", bus17.sum_valid, 1);
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("sum24", bus24.sum, cur.s24);
          check("ovf24", bus24.ovf, cur.o24);
          check("sum17", bus17.sum, cur.s17);
          check("ovf17", bus17.ovf, cur.o17);
        end
      end else if (bus24.sum_valid && !bus24.sum_ready) begin
        check("bp_sum24", bus24.sum, cur.s24);
        check("bp_ovf24", bus24.ovf, cur.o24);
        check("bp_sum17", bus17.sum, cur.s17);
        check("bp_ovf17", bus17.ovf, cur.o17);
        check("bp_in_ready", bus24.in_ready, 0);
      end
      if (bus24.in_valid && bus24.in_ready) last_acc_cyc = cyc;
      prev_sv = bus24.sum_valid;
      prev_hs = bus24.sum_valid && bus24.sum_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

  vec_t vecs [5];
  int   ones [4];
  int   twos [4];
  int   threes [4];
  int   maxv [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_acc_cyc = 0;
    ones   = '{1, 1, 1, 1};
    twos   = '{2, 2, 2, 2};
    threes = '{3, 3, 3, 3};
    maxv   = '{255, 255, 255, 255};

    vecs[0] = '{a: '{15, 24, 23, 6}, b: '{13, 42, 49, 8}, gap: 4'b0000, exp24: 2378,   ovf24: 0, name: "mixed"};
    vecs[1] = '{a: '{0, 0, 0, 0},    b: '{0, 0, 0, 0},    gap: 4'b0000, exp24: 0,      ovf24: 0, name: "zero"};
    vecs[2] = '{a: '{255, 255, 255, 255}, b: '{255, 255, 255, 255}, gap: 4'b0000, exp24: 260100, ovf24: 0, name: "max"};
    vecs[3] = '{a: '{1, 1, 1, 1},    b: '{1, 1, 1, 1},    gap: 4'b0000, exp24: 4,      ovf24: 0, name: "ones"};
    vecs[4] = '{a: '{15, 24, 23, 6}, b: '{13, 42, 49, 8}, gap: 4'b1110, exp24: 2378,   ovf24: 0, name: "mixed_gaps"};

    rst = 1'b1;
    set_in(0, 0, 1'b0);
    set_sr(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus24.in_ready, 0);
    check("rst_sum", bus24.sum, 0);
    check("rst_sum_valid", bus24.sum_valid, 0);
    check("rst_ovf", bus24.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus24.in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      push_frame(vecs[i].a, vecs[i].b, vecs[i].exp24, vecs[i].ovf24);
      for (int j = 0; j < 4; j++) send_pair(vecs[i].a[j], vecs[i].b[j], vecs[i].gap[j]);
      set_in(0, 0, 1'b0);
    end
    wait_drain();

    // Back-pressure: result held 5 extra cycles while a pair waits at the input.
    set_sr(1'b0);
    push_frame(maxv, maxv, 260100, 0);
    for (int j = 0; j < 4; j++) send_pair(255, 255, 1'b0);
    set_in(2, 3, 1'b1);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus24.sum_valid && k < 50);
      if (k >= 50) check("bp_result_timeout", 0, 1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    set_sr(1'b1);
    push_frame(twos, threes, 24, 0);
    for (int j = 0; j < 4; j++) send_pair(2, 3, 1'b0);
    set_in(0, 0, 1'b0);
    wait_drain();

    // Reset after two accepted terms discards them.
    send_pair(7, 9, 1'b0);
    send_pair(11, 13, 1'b0);
    set_in(0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_sum_valid", bus24.sum_valid, 0);
    check("midrst_ovf", bus24.ovf, 0);
    check("midrst_in_ready", bus24.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_frame(ones, ones, 4, 0);
    for (int j = 0; j < 4; j++) send_pair(1, 1, 1'b0);
    set_in(0, 0, 1'b0);
    wait_drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
